ddu_run_ctrl: RTL and testbench

Debug run-control sequencer for the pipeline CPU board.
- Debounces the cont/step/inc/dec board inputs.
- Produces a single clock-enable for the CPU: free run, single step, or halt on a PC breakpoint.
- Drives the debug read address with auto-repeat inc/dec, and packs the LED bus.
- Sits between board I/O and the CPU/DDU read port. Everything runs on clk_500.

---
 rtl/ddu_pkg.sv | 29 ++
 rtl/ddu_debounce.sv | 55 +++++
 rtl/ddu_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_ddu_run_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddu_pkg
// Description : Shared state encoding, button indices and default timing for
//               the debug run-control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ddu_pkg;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_BREAK = 2'd3
    } run_state_t;

    localparam int c_db_cycles_def    = 10;
    localparam int c_repeat_delay_def = 250;
    localparam int c_repeat_rate_def  = 50;
    localparam int c_addr_w_def       = 8;

    // Index of each board button in the conditioned-input vectors
    localparam int c_btn_cont = 0;
    localparam int c_btn_step = 1;
    localparam int c_btn_inc  = 2;
    localparam int c_btn_dec  = 3;

endpackage
`default_nettype wire

// File: rtl/ddu_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ddu_debounce
// Description : Two-flop synchronizer, stable-count level filter and
//               rising-edge press pulse for one raw board button.
// Revision    : 1.0 - initial release
// ============================================================================
module ddu_debounce #(
    parameter int DB_CYCLES = 10
) (
    input  logic clk_500,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_differ;
    logic               w_flip;

    assign w_differ = r_sync2 ^ r_level;
    assign w_flip   = w_differ && (r_cnt == c_cnt_w'(DB_CYCLES - 1));

    always_ff @(posedge clk_500) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!w_differ || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
            if (w_flip) begin
                r_level <= ~r_level;
            end
        end
    end

    // Look-ahead level: consumers act on the same edge the filter commits
    assign level = r_level ^ w_flip;
    assign press = w_flip & ~r_level;

endmodule
`default_nettype wire

// File: rtl/ddu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddu_run_ctrl
// Description : Debug run-control sequencer: CPU clock enable (run / step /
//               breakpoint halt), debug read address with auto-repeat, LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module ddu_run_ctrl
    import ddu_pkg::*;
#(
    parameter int DB_CYCLES    = c_db_cycles_def,
    parameter int REPEAT_DELAY = c_repeat_delay_def,
    parameter int REPEAT_RATE  = c_repeat_rate_def,
    parameter int ADDR_W       = c_addr_w_def
) (
    input  logic              clk_500,
    input  logic              rst,
    input  logic              cont,
    input  logic              step,
    input  logic              inc,
    input  logic              dec,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    input  logic [31:0]       pc_addr,
    output logic              cpu_ce,
    output logic              halted,
    output logic              bp_hit,
    output logic [ADDR_W-1:0] ddu_raddr,
    output logic [15:0]       led
);

    localparam int c_rep_w = $clog2(REPEAT_DELAY + 1);

    logic [3:0]  w_raw;
    logic [3:0]  w_level;
    logic [3:0]  w_press;
    logic [1:0]  w_rep;
    logic        w_addr_up;
    logic        w_addr_dn;
    logic        w_bp_take;
    logic        w_unused;
    run_state_t  r_state;
    logic        r_skip;

    assign w_raw = {dec, inc, step, cont};

    for (genvar gi = 0; gi < 4; gi++) begin : g_db
        ddu_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk_500 (clk_500),
            .rst     (rst),
            .raw     (w_raw[gi]),
            .level   (w_level[gi]),
            .press   (w_press[gi])
        );
    end

    // Counter reloads so that pulses recur every REPEAT_RATE cycles after the first
    for (genvar gi = 0; gi < 2; gi++) begin : g_rep
        logic [c_rep_w-1:0] r_rep_cnt;

        always_ff @(posedge clk_500) begin
            if (rst || !w_level[c_btn_inc + gi]) begin
                r_rep_cnt <= '0;
            end else if (w_rep[gi]) begin
                r_rep_cnt <= c_rep_w'(REPEAT_DELAY - REPEAT_RATE + 1);
            end else begin
                r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
            end
        end

        assign w_rep[gi] = w_level[c_btn_inc + gi] && (r_rep_cnt == c_rep_w'(REPEAT_DELAY));
    end

    assign w_addr_up = w_press[c_btn_inc] | w_rep[0];
    assign w_addr_dn = w_press[c_btn_dec] | w_rep[1];

    always_ff @(posedge clk_500) begin
        if (rst) begin
            ddu_raddr <= '0;
        end else if (w_addr_up && !w_addr_dn) begin
            ddu_raddr <= ddu_raddr + ADDR_W'(1);
        end else if (w_addr_dn && !w_addr_up) begin
            ddu_raddr <= ddu_raddr - ADDR_W'(1);
        end
    end

    assign w_bp_take = bp_en && (pc_addr == bp_addr) && !r_skip;

    always_ff @(posedge clk_500) begin
        if (rst) begin
            r_state <= S_HALT;
            r_skip  <= 1'b0;
            bp_hit  <= 1'b0;
        end else begin
            if (w_press[c_btn_step]) begin
                bp_hit <= 1'b0;
            end
            unique case (r_state)
                S_HALT: begin
                    if (w_level[c_btn_cont]) begin
                        r_state <= S_RUN;
                        r_skip  <= 1'b1;
                    end else if (w_press[c_btn_step]) begin
                        r_state <= S_STEP;
                    end
                end
                S_RUN: begin
                    r_skip <= 1'b0;
                    if (!w_level[c_btn_cont]) begin
                        r_state <= S_HALT;
                    end else if (w_bp_take) begin
                        r_state <= S_BREAK;
                        bp_hit  <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_state <= S_HALT;
                end
                S_BREAK: begin
                    if (!w_level[c_btn_cont]) begin
                        r_state <= S_HALT;
                    end else if (w_press[c_btn_step]) begin
                        r_state <= S_STEP;
                    end
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Enable drops with rst and on a live breakpoint match, never clocking bp_addr
    assign cpu_ce = !rst && ((r_state == S_STEP) || ((r_state == S_RUN) && !w_bp_take));
    assign halted = (r_state != S_RUN);

    assign led[15:8] = pc_addr[7:0];
    if (ADDR_W >= 8) begin : g_led_wide
        assign led[7:0] = ddu_raddr[7:0];
    end else begin : g_led_narrow
        assign led[7:0] = {{(8 - ADDR_W){1'b0}}, ddu_raddr};
    end

    assign w_unused = &{1'b0, w_level[c_btn_step], w_press[c_btn_cont]};

endmodule
`default_nettype wire

// File: tb/tb_ddu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddu_run_ctrl
// Description : Directed self-checking bench for ddu_run_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddu_run_ctrl;

    logic        clk_500 = 1'b0;
    logic        rst;
    logic        cont;
    logic        step;
    logic        inc;
    logic        dec;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc_addr;
    logic        cpu_ce;
    logic        halted;
    logic        bp_hit;
    logic [7:0]  ddu_raddr;
    logic [15:0] led;

    int tests_run    = 0;
    int tests_failed = 0;
    logic ramp = 1'b0;

    always #5 clk_500 = ~clk_500;

    ddu_run_ctrl #(
        .DB_CYCLES    (10),
        .REPEAT_DELAY (250),
        .REPEAT_RATE  (50),
        .ADDR_W       (8)
    ) dut (
        .clk_500   (clk_500),
        .rst       (rst),
        .cont      (cont),
        .step      (step),
        .inc       (inc),
        .dec       (dec),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc_addr   (pc_addr),
        .cpu_ce    (cpu_ce),
        .halted    (halted),
        .bp_hit    (bp_hit),
        .ddu_raddr (ddu_raddr),
        .led       (led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: CPU model advances PC by 4 on every enabled edge when ramping
    task automatic tick();
        logic ce;
        #1;
        ce = cpu_ce;
        @(posedge clk_500);
        #1;
        if (ramp && ce) pc_addr = pc_addr + 32'd4;
        #1;
    endtask

    task automatic press(input logic do_inc, input logic do_dec, input int hold);
        inc = do_inc;
        dec = do_dec;
        repeat (hold) tick();
        inc = 1'b0;
        dec = 1'b0;
        repeat (15) tick();
    endtask

    initial begin
        int n;
        int k;
        rst = 1'b1; cont = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; pc_addr = 32'h5A;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        check("rst_raddr", 32'(ddu_raddr), 32'd0);
        check("rst_led", 32'(led), 32'h5A00);

        // 5-cycle glitch on step must be filtered out
        step = 1'b1;
        repeat (5) tick();
        step = 1'b0;
        n = 0;
        repeat (25) begin tick(); n += int'(cpu_ce); end
        check("glitch_ce_cycles", n, 0);

        // Clean step press: one enable cycle, 12 cycles after the input rises
        step = 1'b1;
        n = 0; k = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 20) step = 1'b0;
            if (cpu_ce && k == 0) k = i;
            n += int'(cpu_ce);
        end
        check("step_latency", k, 12);
        check("step_ce_cycles", n, 1);

        // Address presses and wrap
        repeat (3) press(1'b1, 1'b0, 15);
        check("inc3_raddr", 32'(ddu_raddr), 32'd3);
        repeat (4) press(1'b0, 1'b1, 15);
        check("dec4_raddr", 32'(ddu_raddr), 32'd255);
        check("dec4_led_lo", 32'(led[7:0]), 32'hFF);
        press(1'b1, 1'b1, 15);
        check("both_raddr", 32'(ddu_raddr), 32'd255);

        // Auto-repeat: press at 12 wraps 255->0, repeats at 262/312/362
        inc = 1'b1;
        repeat (100) tick();
        check("rep_first_raddr", 32'(ddu_raddr), 32'd0);
        repeat (280) tick();
        check("rep_380_raddr", 32'(ddu_raddr), 32'd3);
        inc = 1'b0;
        repeat (20) tick();
        check("rep_release_raddr", 32'(ddu_raddr), 32'd3);

        // Breakpoint while running with a ramping PC
        bp_en = 1'b1; bp_addr = 32'h10; pc_addr = 32'h0; ramp = 1'b1; cont = 1'b1;
        n = 0;
        while (pc_addr != 32'h10 && n < 60) begin tick(); n++; end
        check("bp_reached_pc", pc_addr, 32'h10);
        check("bp_cycle_ce", 32'(cpu_ce), 32'd0);
        check("bp_cycle_halted", 32'(halted), 32'd0);
        tick();
        check("break_halted", 32'(halted), 32'd1);
        check("break_bp_hit", 32'(bp_hit), 32'd1);
        check("break_ce", 32'(cpu_ce), 32'd0);
        repeat (5) tick();
        check("break_pc_hold", pc_addr, 32'h10);

        // Step out of BREAK
        step = 1'b1;
        k = 0;
        while (!cpu_ce && k < 40) begin tick(); k++; end
        check("brk_step_latency", k, 12);
        check("brk_step_halted", 32'(halted), 32'd1);
        check("brk_step_bp_hit", 32'(bp_hit), 32'd0);
        tick();
        check("brk_step_single", 32'(cpu_ce), 32'd0);
        check("brk_step_pc", pc_addr, 32'h14);
        step = 1'b0;
        cont = 1'b0;
        repeat (30) tick();
        check("cont_off_halted", 32'(halted), 32'd1);
        check("cont_off_bp_hit", 32'(bp_hit), 32'd0);

        // Resume at the breakpoint PC: first RUN cycle is enabled
        ramp = 1'b0; pc_addr = 32'h10; cont = 1'b1;
        n = 0;
        while (halted && n < 40) begin tick(); n++; end
        check("resume_latency", n, 12);
        check("resume_ce", 32'(cpu_ce), 32'd1);
        tick();
        check("rebreak_ce", 32'(cpu_ce), 32'd0);
        tick();
        check("rebreak_halted", 32'(halted), 32'd1);
        check("rebreak_bp_hit", 32'(bp_hit), 32'd1);

        // Reset in the middle of a run
        cont = 1'b0;
        repeat (30) tick();
        bp_en = 1'b0; cont = 1'b1;
        n = 0;
        while (halted && n < 40) begin tick(); n++; end
        check("prerst_run_ce", 32'(cpu_ce), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_run_ce_drop", 32'(cpu_ce), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_raddr", 32'(ddu_raddr), 32'd0);
        check("midrst_halted", 32'(halted), 32'd1);
        check("midrst_bp_hit", 32'(bp_hit), 32'd0);
        check("midrst_ce", 32'(cpu_ce), 32'd0);
        n = 0;
        while (halted && n < 50) begin tick(); n++; end
        check("midrst_rerun_cycles", n, 12);
        check("midrst_rerun_ce", 32'(cpu_ce), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
